// File: rtl/bp_processor_set.sv
// Backpropagation processor set: accumulates wt*delta products over fo beats and
// emits adot-scaled left-layer deltas. Define MULT_PIPELINE_EN to register both multiplies (L=3).
module bp_processor_set #(
  parameter int z        = 32,
  parameter int fi       = 16,
  parameter int fo       = 2,
  parameter int width    = 10,
  parameter int int_bits = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [width*z/fi-1:0]       del_in_package,
  input  logic [width*z-1:0]          wt_package,
  input  logic [width*z-1:0]          adot_package,
  output logic                        out_valid,
  output logic [width*z-1:0]          del_out_package,
  output logic [$clog2(fo+1)-1:0]     beat_cnt
);

  localparam int FRAC = width - int_bits - 1;
  localparam int CW   = $clog2(fo + 1);
  localparam int PW   = 2 * width;
  localparam int AW   = 2 * width + $clog2(fo) + 1;

  function automatic logic signed [PW-1:0] mul_w(input logic signed [width-1:0] a,
                                                 input logic signed [width-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  function automatic logic signed [width-1:0] sat_w(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] hi;
    logic signed [AW-1:0] lo;
    hi = {{(AW-width+1){1'b0}}, {(width-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      return {1'b0, {(width-1){1'b1}}};
    else if (v < lo) return {1'b1, {(width-1){1'b0}}};
    else             return v[width-1:0];
  endfunction

  logic                 accept, last;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [PW-1:0] p_c [z];

  always_comb begin
    accept = in_valid & ~reset;
    last   = accept && (cnt_q == CW'(fo - 1));
    cnt_d  = cnt_q;
    if (accept) cnt_d = last ? '0 : cnt_q + CW'(1);
    for (int unsigned i = 0; i < z; i++)
      p_c[i] = mul_w(wt_package[width*i +: width], del_in_package[width*(i/fi) +: width]);
  end

  // Accumulator input: either the raw beat or the registered product stage.
  logic                 src_v, src_last;
  logic signed [PW-1:0] p_src [z];
  logic [width*z-1:0]   adot_src;

`ifdef MULT_PIPELINE_EN
  logic                 pv_q, pv_d, pl_q, pl_d;
  logic signed [PW-1:0] prod_q [z];
  logic signed [PW-1:0] prod_d [z];
  logic [width*z-1:0]   padot_q, padot_d;

  always_comb begin
    pv_d    = accept;
    pl_d    = last;
    padot_d = last ? adot_package : padot_q;
    for (int unsigned i = 0; i < z; i++) prod_d[i] = accept ? p_c[i] : prod_q[i];
    src_v    = pv_q;
    src_last = pl_q;
    adot_src = padot_q;
    for (int unsigned i = 0; i < z; i++) p_src[i] = prod_q[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q    <= 1'b0;
      pl_q    <= 1'b0;
      padot_q <= '0;
      for (int unsigned i = 0; i < z; i++) prod_q[i] <= '0;
    end else begin
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      padot_q <= padot_d;
      for (int unsigned i = 0; i < z; i++) prod_q[i] <= prod_d[i];
    end
  end
`else
  always_comb begin
    src_v    = accept;
    src_last = last;
    adot_src = adot_package;
    for (int unsigned i = 0; i < z; i++) p_src[i] = p_c[i];
  end
`endif

  logic signed [AW-1:0] acc_q [z];
  logic signed [AW-1:0] acc_d [z];
  logic signed [AW-1:0] tot_q [z];
  logic signed [AW-1:0] tot_d [z];
  logic                 tv_q, tv_d;
  logic [width*z-1:0]   tadot_q, tadot_d;

  // The last beat bypasses acc into tot so the next group can start immediately.
  always_comb begin
    tv_d    = src_v & src_last;
    tadot_d = tv_d ? adot_src : tadot_q;
    for (int unsigned i = 0; i < z; i++) begin
      acc_d[i] = acc_q[i];
      tot_d[i] = tot_q[i];
      if (src_v) begin
        if (src_last) begin
          acc_d[i] = '0;
          tot_d[i] = acc_q[i] + AW'(p_src[i]);
        end else begin
          acc_d[i] = acc_q[i] + AW'(p_src[i]);
        end
      end
    end
  end

  logic signed [width-1:0] s_c [z];
  logic signed [PW-1:0]    m_c [z];
  logic                    fin_v;
  logic signed [PW-1:0]    fin_m [z];

  always_comb begin
    for (int unsigned i = 0; i < z; i++) begin
      s_c[i] = sat_w(tot_q[i] >>> FRAC);
      m_c[i] = mul_w(s_c[i], tadot_q[width*i +: width]);
    end
  end

`ifdef MULT_PIPELINE_EN
  logic                 mv_q, mv_d;
  logic signed [PW-1:0] mult_q [z];
  logic signed [PW-1:0] mult_d [z];

  always_comb begin
    mv_d  = tv_q;
    fin_v = mv_q;
    for (int unsigned i = 0; i < z; i++) begin
      mult_d[i] = tv_q ? m_c[i] : mult_q[i];
      fin_m[i]  = mult_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mv_q <= 1'b0;
      for (int unsigned i = 0; i < z; i++) mult_q[i] <= '0;
    end else begin
      mv_q <= mv_d;
      for (int unsigned i = 0; i < z; i++) mult_q[i] <= mult_d[i];
    end
  end
`else
  always_comb begin
    fin_v = tv_q;
    for (int unsigned i = 0; i < z; i++) fin_m[i] = m_c[i];
  end
`endif

  logic               out_valid_q, out_valid_d;
  logic [width*z-1:0] del_out_q, del_out_d;

  always_comb begin
    out_valid_d = fin_v;
    del_out_d   = del_out_q;
    if (fin_v)
      for (int unsigned i = 0; i < z; i++)
        del_out_d[width*i +: width] = sat_w(AW'(fin_m[i]) >>> FRAC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      tv_q        <= 1'b0;
      tadot_q     <= '0;
      out_valid_q <= 1'b0;
      del_out_q   <= '0;
      for (int unsigned i = 0; i < z; i++) begin
        acc_q[i] <= '0;
        tot_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      tv_q        <= tv_d;
      tadot_q     <= tadot_d;
      out_valid_q <= out_valid_d;
      del_out_q   <= del_out_d;
      for (int unsigned i = 0; i < z; i++) begin
        acc_q[i] <= acc_d[i];
        tot_q[i] <= tot_d[i];
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign del_out_package = del_out_q;
  assign beat_cnt        = cnt_q;

endmodule

// File: tb/tb_bp_processor_set.sv
// Bench for bp_processor_set: integer reference model plus directed literal groups and random traffic.
module tb_bp_processor_set;
  localparam int Z  = 32;
  localparam int FI = 16;
  localparam int FO = 2;
  localparam int W  = 10;
  localparam int IB = 2;
  localparam int FR = W - IB - 1;
  localparam int NR = Z / FI;
  localparam int CW = $clog2(FO + 1);
  localparam int PK = W * Z;
`ifdef MULT_PIPELINE_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic          clk = 1'b0;
  logic          reset, in_valid;
  logic [W*NR-1:0] del_in;
  logic [PK-1:0] wt, adot, del_out;
  logic          out_valid;
  logic [CW-1:0] beat_cnt;

  always #5 clk = ~clk;

  bp_processor_set #(.z(Z), .fi(FI), .fo(FO), .width(W), .int_bits(IB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .del_in_package(del_in), .wt_package(wt), .adot_package(adot),
    .out_valid(out_valid), .del_out_package(del_out), .beat_cnt(beat_cnt)
  );

  // ---------------- reference model ----------------
  typedef struct { int due; logic [PK-1:0] data; } grp_t;
  grp_t        q[$];
  grp_t        g;
  int          cyc = 0;
  int          msum [Z];
  int          mcnt = 0;
  bit          exp_v = 1'b0;
  logic [PK-1:0] exp_out = '0;

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat(input int v);
    if (v > (1 << (W-1)) - 1) return (1 << (W-1)) - 1;
    if (v < -(1 << (W-1)))    return -(1 << (W-1));
    return v;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      q.delete();
      for (int i = 0; i < Z; i++) msum[i] = 0;
      mcnt    = 0;
      exp_v   = 1'b0;
      exp_out = '0;
    end else begin
      if (in_valid) begin
        for (int i = 0; i < Z; i++)
          msum[i] = msum[i] + sx(wt[W*i +: W]) * sx(del_in[W*(i/FI) +: W]);
        if (mcnt == FO - 1) begin
          g.due = cyc + L;
          for (int i = 0; i < Z; i++) begin
            g.data[W*i +: W] = W'(sat((sat(msum[i] >>> FR) * sx(adot[W*i +: W])) >>> FR));
            msum[i] = 0;
          end
          q.push_back(g);
          mcnt = 0;
        end else begin
          mcnt = mcnt + 1;
        end
      end
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_v   = 1'b1;
        exp_out = q[0].data;
        void'(q.pop_front());
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [PK-1:0] act, input logic [PK-1:0] exp);
    int idx;
    idx = 0;
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = Z - 1; i >= 0; i--) if (act[W*i +: W] !== exp[W*i +: W]) idx = i;
      $display("FAIL %s elem %0d got %h want %h (t=%0t)", name, idx, act[W*idx +: W], exp[W*idx +: W], $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W*NR-1:0] d, input logic [PK-1:0] w,
                       input logic [PK-1:0] a);
    @(posedge clk);
    #1;
    in_valid = v; del_in = d; wt = w; adot = a;
  endtask

  task automatic wait_pulse(input logic [PK-1:0] exp, input string name);
    int k;
    bit got;
    k = 0; got = 1'b0;
    for (int n = 1; n <= 12 && !got; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin got = 1'b1; k = n; end
    end
    chk({name, "_seen"}, PK'(got), PK'(1));
    chk({name, "_lat"}, PK'(k), PK'(L + 1));
    chk(name, del_out, exp);
    @(negedge clk);
    chk({name, "_single"}, PK'(out_valid), PK'(0));
  endtask

  task automatic group2(input logic [W*NR-1:0] d, input logic [PK-1:0] w,
                        input logic [PK-1:0] a, input logic [PK-1:0] exp, input string name);
    drive(1'b1, d, w, a);
    drive(1'b1, d, w, a);
    drive(1'b0, '0, '0, '0);
    wait_pulse(exp, name);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < Z; i++) begin
      wt[W*i +: W]   = ($urandom % 2) ? W'($urandom) : W'(int'($urandom_range(0, 96)) - 48);
      adot[W*i +: W] = ($urandom % 2) ? W'($urandom) : W'($urandom_range(0, 160));
    end
    for (int k = 0; k < NR; k++)
      del_in[W*k +: W] = ($urandom % 2) ? W'($urandom) : W'(int'($urandom_range(0, 96)) - 48);
  endtask

  localparam logic [W-1:0] ONE = 10'h080;

  initial begin
    int npulse, p0, p1;
    reset = 1'b1;
    in_valid = 1'b1;
    rand_inputs();

    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          chk("mon_valid", PK'(out_valid), PK'(exp_v));
          chk("mon_data", del_out, exp_out);
          chk("mon_cnt", PK'(beat_cnt), PK'(mcnt));
        end
      end
    join_none

    // Reset held with live random beats
    repeat (5) begin
      @(posedge clk);
      #1 rand_inputs();
    end
    @(negedge clk);
    chk("rst_valid", PK'(out_valid), PK'(0));
    chk("rst_data", del_out, PK'(0));
    chk("rst_cnt", PK'(beat_cnt), PK'(0));
    @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
    mon_en = 1'b1;

    group2({NR{ONE}}, {Z{10'h040}}, {Z{ONE}}, {Z{10'h080}}, "basic");
    // Upper half: 4.0 saturates to 511 before the 0.5 scale, landing on 0x0FF
    group2({10'h100, 10'h380}, {Z{ONE}}, {Z{10'h040}}, {{16{10'h0FF}}, {16{10'h380}}}, "mixed");
    group2({NR{10'h180}}, {Z{10'h180}}, {Z{ONE}}, {Z{10'h1FF}}, "sat_pos");
    group2({NR{10'h280}}, {Z{10'h180}}, {Z{ONE}}, {Z{10'h200}}, "sat_neg");

    drive(1'b1, {NR{ONE}}, {Z{10'h040}}, {Z{ONE}});
    repeat (3) begin
      drive(1'b0, '0, '0, '0);
      @(negedge clk);
      chk("gap_cnt", PK'(beat_cnt), PK'(1));
    end
    drive(1'b1, {NR{ONE}}, {Z{10'h040}}, {Z{ONE}});
    drive(1'b0, '0, '0, '0);
    wait_pulse({Z{10'h080}}, "gap");

    // Pre-reset beat uses different data so a leak would alter the first group
    drive(1'b1, {NR{ONE}}, {Z{ONE}}, {Z{ONE}});
    @(posedge clk);
    #1 reset = 1'b1; in_valid = 1'b0;
    npulse = 0; p0 = -1; p1 = -1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1 reset = 1'b0;
      in_valid = (n < 4);
      del_in = {NR{10'h020}}; wt = {Z{ONE}}; adot = {Z{ONE}};
      @(negedge clk);
      if (out_valid === 1'b1) begin
        npulse++;
        if (p0 < 0) p0 = n; else p1 = n;
        chk("robust_data", del_out, {Z{10'h040}});
      end
    end
    chk("robust_count", PK'(npulse), PK'(2));
    chk("robust_gap", PK'(p1 - p0), PK'(2));

    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      reset = ($urandom % 60 == 0);
      in_valid = ($urandom % 4 != 0);
      rand_inputs();
    end
    @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
